// File: rtl/calc_pkg.sv
// Shared opcode encodings and controller state enum for iter_calculator.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_SQUARE = 2'd0,
    OP_CUBE   = 2'd1,
    OP_FACT   = 2'd2,
    OP_RSVD   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sat_mul.sv
// Combinational OW x W unsigned multiplier that saturates to all-ones when the
// full-width product does not fit in OW bits.
module sat_mul #(
  parameter int W  = 4,
  parameter int OW = 16
) (
  input  logic [OW-1:0] a,
  input  logic [W-1:0]  b,
  output logic [OW-1:0] y,
  output logic          ovf
);

  logic [OW+W-1:0] prod;

  // Full-width product, then clamp on any bit above OW.
  always_comb begin
    prod = {{W{1'b0}}, a} * {{OW{1'b0}}, b};
    ovf  = |prod[OW+W-1:OW];
    y    = ovf ? {OW{1'b1}} : prod[OW-1:0];
  end

endmodule

// File: rtl/iter_calculator.sv
// Iterative square / cube / factorial unit with a saturating accumulator and a
// valid/ready handshake on both sides.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | in_ready high, waiting for a request
//   CALC    | one acc*operand step per cycle, iteration counter counts down
//   DONE    | result held on out/ovf/err until out_ready
module iter_calculator
  import calc_pkg::*;
#(
  parameter int W  = 4,
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in,
  input  logic [1:0]    opcode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out,
  output logic          ovf,
  output logic          err
);

  state_t        state;
  state_t        state_nxt;

  logic [OW-1:0] acc;
  logic [W-1:0]  oper;
  logic [W-1:0]  iter_cnt;
  logic          is_fact;
  logic          ovf_q;
  logic          err_q;

  logic          accept;
  logic [OW-1:0] load_acc;
  logic [W-1:0]  load_oper;
  logic [W-1:0]  load_iter;
  logic          load_err;

  logic [OW-1:0] mul_y;
  logic          mul_ovf;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid & in_ready;

  sat_mul #(.W(W), .OW(OW)) u_sat_mul (
    .a   (acc),
    .b   (oper),
    .y   (mul_y),
    .ovf (mul_ovf)
  );

  // Decode the request into initial accumulator, operand and iteration count.
  always_comb begin
    load_acc  = '0;
    load_oper = in;
    load_iter = '0;
    load_err  = 1'b0;
    case (op_t'(opcode))
      OP_SQUARE: begin
        load_acc  = {{(OW-W){1'b0}}, in};
        load_iter = W'(1);
      end
      OP_CUBE: begin
        load_acc  = {{(OW-W){1'b0}}, in};
        load_iter = W'(2);
      end
      OP_FACT: begin
        load_acc  = OW'(1);
        load_oper = W'(2);
        load_iter = (in > W'(1)) ? (in - W'(1)) : '0;
      end
      default: begin
        load_err = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the iteration counter terminal count ends CALC.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (load_iter != '0) ? ST_CALC : ST_DONE;
      ST_CALC: if (iter_cnt == W'(1)) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load on accept, multiply-step in CALC, clear after handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      oper     <= '0;
      iter_cnt <= '0;
      is_fact  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc      <= load_acc;
            oper     <= load_oper;
            iter_cnt <= load_iter;
            is_fact  <= (op_t'(opcode) == OP_FACT);
            ovf_q    <= 1'b0;
            err_q    <= load_err;
          end
        end
        ST_CALC: begin
          // Once saturated the accumulator stays pinned for the whole operation.
          acc      <= ovf_q ? {OW{1'b1}} : mul_y;
          ovf_q    <= ovf_q | mul_ovf;
          iter_cnt <= iter_cnt - W'(1);
          if (is_fact) oper <= oper + W'(1);
        end
        ST_DONE: begin
          if (out_ready) begin
            acc      <= '0;
            oper     <= '0;
            iter_cnt <= '0;
            is_fact  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Result outputs read zero unless a result is being presented.
  always_comb begin
    out_valid = (state == ST_DONE);
    out       = out_valid ? acc : '0;
    ovf       = out_valid & ovf_q;
    err       = out_valid & err_q;
  end

endmodule

// File: tb/tb_iter_calculator.sv
// Self-checking bench for iter_calculator (W=4, OW=16): directed vector table,
// hand-written stall/reset sequences, and random ops against a reference model.
module tb_iter_calculator;

  localparam int  W    = 4;
  localparam int  OW   = 16;
  localparam longint MAXV = (64'd1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  op_x = '0;
  logic [1:0]    op_code = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] res;
  logic          ovf;
  logic          err;

  int n_vec = 0;
  int n_mis = 0;

  iter_calculator #(.W(W), .OW(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (op_x),
    .opcode    (op_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (res),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int x;
    int exp_out;
    int exp_ovf;
    int exp_err;
    int exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: result from plain arithmetic on the operation definition.
  task automatic ref_model(input int op, input int x, output longint e_out,
                           output int e_ovf, output int e_err, output int e_lat);
    longint f;
    e_err = 0;
    case (op)
      0: begin f = longint'(x) * x;     e_lat = 2; end
      1: begin f = longint'(x) * x * x; e_lat = 3; end
      2: begin
        f = 1;
        for (int k = 2; k <= x; k++) f = f * k;
        e_lat = ((x > 1) ? x - 1 : 0) + 1;
      end
      default: begin f = 0; e_err = 1; e_lat = 1; end
    endcase
    e_ovf = (f > MAXV) ? 1 : 0;
    e_out = (f > MAXV) ? MAXV : f;
  endtask

  // Issue one request; stall = cycles out_ready stays low after out_valid.
  task automatic run_op(input int op, input int x, input int stall,
                        output longint g_out, output int g_ovf,
                        output int g_err, output int g_lat);
    @(negedge clk);
    check("in_ready_before_req", in_ready, 1);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    op_code   = op[1:0];
    op_x      = x[W-1:0];
    @(posedge clk);
    g_lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      g_lat++;
    end while (!out_valid && g_lat < 40);
    g_out = res;
    g_ovf = ovf;
    g_err = err;
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      check("stall_hold_out", res, g_out);
      check("stall_hold_valid", out_valid, 1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("valid_drop_after_handshake", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint g_out, e_out;
    int g_ovf, g_err, g_lat, e_ovf, e_err, e_lat, seen;

    vecs[0]  = '{0,  7, 49,    0, 0, 2};
    vecs[1]  = '{1, 15, 3375,  0, 0, 3};
    vecs[2]  = '{2,  0, 1,     0, 0, 1};
    vecs[3]  = '{2,  1, 1,     0, 0, 1};
    vecs[4]  = '{2,  8, 40320, 0, 0, 8};
    vecs[5]  = '{2,  9, 65535, 1, 0, 9};
    vecs[6]  = '{2,  5, 120,   0, 0, 5};
    vecs[7]  = '{3,  5, 0,     0, 1, 1};
    vecs[8]  = '{0, 15, 225,   0, 0, 2};
    vecs[9]  = '{1,  0, 0,     0, 0, 3};
    vecs[10] = '{2, 15, 65535, 1, 0, 15};

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid_rel", out_valid, 0);
    check("rst_out", res, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].x, 0, g_out, g_ovf, g_err, g_lat);
      check($sformatf("vec%0d_out", i), g_out, vecs[i].exp_out);
      check($sformatf("vec%0d_ovf", i), g_ovf, vecs[i].exp_ovf);
      check($sformatf("vec%0d_err", i), g_err, vecs[i].exp_err);
      check($sformatf("vec%0d_lat", i), g_lat, vecs[i].exp_lat);
    end

    // Reserved opcode with a 10-cycle consumer stall; new requests ignored
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op_code   = 2'd3;
    op_x      = 4'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("rsvd_valid", out_valid, 1);
    check("rsvd_out", res, 0);
    check("rsvd_err", err, 1);
    check("rsvd_ovf", ovf, 0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      op_code  = 2'd0;
      op_x     = 4'd3;
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_out", res, 0);
      check("stall_err", err, 1);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rsvd_release_valid", out_valid, 0);
    check("rsvd_release_err_gated", err, 0);
    check("rsvd_release_in_ready", in_ready, 1);
    @(negedge clk);
    check("no_buffered_req", out_valid, 0);

    // Reset in the middle of factorial x=6
    @(negedge clk);
    in_valid = 1'b1;
    op_code  = 2'd2;
    op_x     = 4'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_calc_busy", in_ready, 0);
    rst = 1'b1;
    #1;
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out", res, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("dropped_op_no_result", seen, 0);
    run_op(0, 3, 0, g_out, g_ovf, g_err, g_lat);
    check("post_rst_square_out", g_out, 9);
    check("post_rst_square_lat", g_lat, 2);

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      int op, x, st;
      op = $urandom_range(0, 3);
      x  = $urandom_range(0, 15);
      st = $urandom_range(0, 3);
      ref_model(op, x, e_out, e_ovf, e_err, e_lat);
      run_op(op, x, st, g_out, g_ovf, g_err, g_lat);
      check($sformatf("rnd%0d_op%0d_x%0d_out", i, op, x), g_out, e_out);
      check($sformatf("rnd%0d_op%0d_x%0d_ovf", i, op, x), g_ovf, e_ovf);
      check($sformatf("rnd%0d_op%0d_x%0d_err", i, op, x), g_err, e_err);
      check($sformatf("rnd%0d_op%0d_x%0d_lat", i, op, x), g_lat, e_lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
